fir_row_sched: RTL

Sequencer and stream controller in front of the 4-tap LUT FIR core. It accepts a pixel stream with a valid/ready handshake and slices it into image rows. Before each row it flushes the core's internal delay registers with zero samples, so no history leaks across row edges. It drives the core's sample input and clock-enable, captures `filtop` into a backpressure-aware output register, and tags row and frame boundaries. It is the row pass of the 2D FIR.

---
 rtl/fir_pkg.sv | 13 +
 rtl/rowcol_cnt.sv | 39 +++
 rtl/fir_row_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and widths for the row-pass FIR scheduler.
package fir_pkg;
  localparam int PIX_W    = 8;
  localparam int Y_W      = 12;
  localparam int TAPS_DEF = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_STREAM} state_t;

  // Bits needed to hold a count in 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rowcol_cnt.sv
// Column/row position counter; column wraps into a row step.
module rowcol_cnt import fir_pkg::*; #(
  parameter int W = 64,
  parameter int H = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [cnt_w(W)-1:0] o_col,
  output logic [cnt_w(H)-1:0] o_row,
  output logic                o_at_last_col,
  output logic                o_at_last_row
);
  localparam int CW = cnt_w(W);
  localparam int RW = cnt_w(H);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_col         = r_col;
  assign o_row         = r_row;
  assign o_at_last_col = (r_col == CW'(W-1));
  assign o_at_last_row = (r_row == RW'(H-1));

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (o_at_last_col) begin
        r_col <= '0;
        r_row <= o_at_last_row ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/fir_row_sched.sv
// Row sequencer for the LUT FIR core: flushes core history before each row,
// streams pixels through, and registers the filtered result with backpressure.
module fir_row_sched import fir_pkg::*; #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int TAPS  = TAPS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pix,
  input  logic             s_sof,
  output logic [PIX_W-1:0] filt_x,
  output logic             filt_ce,
  input  logic [Y_W-1:0]   filt_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [Y_W-1:0]   m_data,
  output logic             m_sof,
  output logic             m_last,
  output logic             frame_done,
  output logic             sof_err
);
  localparam int FW = cnt_w(TAPS-1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(TAPS-2);

  state_t                 r_state;
  logic [FW-1:0]          r_fcnt;
  logic                   r_m_valid, r_m_sof, r_m_last, r_frame_done, r_sof_err;
  logic [Y_W-1:0]         r_m_data;
  logic [cnt_w(IMG_W)-1:0] w_col;
  logic [cnt_w(IMG_H)-1:0] w_row;
  logic w_at_last_col, w_at_last_row, w_first, w_ld, w_acc, w_sof_err;
  logic w_s_ready, w_filt_ce;
  logic [PIX_W-1:0] w_filt_x;

  rowcol_cnt #(.W(IMG_W), .H(IMG_H)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inc        (w_acc),
    .i_clr        ((r_state == ST_IDLE) || w_sof_err),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_at_last_col(w_at_last_col),
    .o_at_last_row(w_at_last_row)
  );

  assign w_first   = (w_row == '0) && (w_col == '0);
  assign w_ld      = !r_m_valid || m_ready;
  assign w_acc     = (r_state == ST_STREAM) && s_valid && w_s_ready;
  assign w_sof_err = (r_state == ST_STREAM) && s_valid && s_sof && !w_first;

  always_comb begin
    w_s_ready = 1'b0;
    w_filt_x  = '0;
    w_filt_ce = 1'b0;
    case (r_state)
      ST_IDLE:   w_s_ready = !s_sof;
      ST_FLUSH:  w_filt_ce = 1'b1;
      ST_STREAM: begin
        w_s_ready = w_ld && !(s_sof && !w_first);
        w_filt_x  = s_pix;
        w_filt_ce = s_valid && w_s_ready;
      end
      default: ;
    endcase
  end

  // Handshake outputs are held low while reset is asserted.
  assign s_ready    = rst_n && w_s_ready;
  assign filt_ce    = rst_n && w_filt_ce;
  assign filt_x     = rst_n ? w_filt_x : '0;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_sof      = r_m_sof;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fcnt       <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_sof      <= 1'b0;
      r_m_last     <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
      if (w_ld) begin
        if (w_acc) begin
          r_m_valid <= 1'b1;
          r_m_data  <= filt_y;
          r_m_sof   <= w_first;
          r_m_last  <= w_at_last_col;
        end else begin
          r_m_valid <= 1'b0;
        end
      end
      case (r_state)
        ST_IDLE: if (s_valid && s_sof) begin
          r_state <= ST_FLUSH;
          r_fcnt  <= '0;
        end
        ST_FLUSH: begin
          if (r_fcnt == FLUSH_LAST) begin
            r_state <= ST_STREAM;
            r_fcnt  <= '0;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        ST_STREAM: begin
          if (w_sof_err) begin
            // New frame starts mid-frame: restart from a clean flush.
            r_sof_err <= 1'b1;
            r_state   <= ST_FLUSH;
            r_fcnt    <= '0;
          end else if (w_acc && w_at_last_col) begin
            r_fcnt <= '0;
            if (w_at_last_row) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_state <= ST_FLUSH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
